// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: detects load-use, long-op RAW/WAW and long-unit
// structural hazards in ID, and drives stall/issue/bubble for the front end.
module hazard_scoreboard #(
  parameter int LONG_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_long,
  input  logic             EX_flush,
  input  logic             long_done,
  output logic             stall,
  output logic             issue,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             long_timeout,
  output logic             protocol_err
);

  localparam int TMO_W = $clog2(LONG_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(LONG_TIMEOUT);

  logic             load_pending_q, load_pending_d;
  logic [4:0]       load_rd_q, load_rd_d;
  logic             long_pending_q, long_pending_d;
  logic [4:0]       long_rd_q, long_rd_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             long_timeout_q, long_timeout_d;
  logic             protocol_err_q, protocol_err_d;

  logic load_use, long_raw, long_waw, long_struct, long_start;

  // Register x0 never carries a dependency, so every match excludes it.
  always_comb begin
    load_use    = load_pending_q && (load_rd_q != 5'd0) &&
                  ((ID_use_rs1 && (ID_rs1 == load_rd_q)) ||
                   (ID_use_rs2 && (ID_rs2 == load_rd_q)));
    long_raw    = long_pending_q && (long_rd_q != 5'd0) &&
                  ((ID_use_rs1 && (ID_rs1 == long_rd_q)) ||
                   (ID_use_rs2 && (ID_rs2 == long_rd_q)));
    long_waw    = long_pending_q && ID_RegWrite && (ID_rd != 5'd0) &&
                  (ID_rd == long_rd_q);
    long_struct = long_pending_q && ID_long;
    stall       = ID_valid && !EX_flush &&
                  (load_use || long_raw || long_waw || long_struct);
    issue       = ID_valid && !EX_flush && !stall;
    bubble      = !issue;
    long_start  = issue && ID_long;
  end

  always_comb begin
    load_pending_d = issue && ID_MemRead && ID_RegWrite;
    load_rd_d      = ID_rd;
    long_pending_d = long_pending_q;
    long_rd_d      = long_rd_q;
    tmo_cnt_d      = tmo_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    long_timeout_d = long_timeout_q;
    protocol_err_d = protocol_err_q;

    // A new long op can only issue while none is pending, so start and done
    // never refer to the same op; a done with nothing pending is a protocol error.
    if (long_start) begin
      long_pending_d = 1'b1;
      long_rd_d      = ID_rd;
      tmo_cnt_d      = '0;
    end else if (long_pending_q) begin
      if (long_done) begin
        long_pending_d = 1'b0;
      end
      if (tmo_cnt_q != TMO_MAX) begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end

    if (long_done && !long_pending_q) begin
      protocol_err_d = 1'b1;
    end
    if (long_pending_q && (tmo_cnt_d == TMO_MAX)) begin
      long_timeout_d = 1'b1;
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_pending_q <= 1'b0;
      load_rd_q      <= 5'd0;
      long_pending_q <= 1'b0;
      long_rd_q      <= 5'd0;
      tmo_cnt_q      <= '0;
      stall_cnt_q    <= '0;
      long_timeout_q <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      load_pending_q <= load_pending_d;
      load_rd_q      <= load_rd_d;
      long_pending_q <= long_pending_d;
      long_rd_q      <= long_rd_d;
      tmo_cnt_q      <= tmo_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      long_timeout_q <= long_timeout_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign long_timeout = long_timeout_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard: load-use, long RAW/WAW/structural,
// flush, timeout, protocol error and reset scenarios with hand-computed results.
module tb_hazard_scoreboard;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             ID_valid, ID_use_rs1, ID_use_rs2, ID_RegWrite, ID_MemRead, ID_long;
  logic [4:0]       ID_rs1, ID_rs2, ID_rd;
  logic             EX_flush, long_done;
  logic             stall, issue, bubble, long_timeout, protocol_err;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.LONG_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_rd(ID_rd),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_long(ID_long),
    .EX_flush(EX_flush), .long_done(long_done),
    .stall(stall), .issue(issue), .bubble(bubble), .stall_cnt(stall_cnt),
    .long_timeout(long_timeout), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive the ID slot; r1/r2 of 0 with use flags set still count as "used".
  task automatic applyStimulus(input logic v, input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2,
                               input logic [4:0] rd, input logic wr, input logic mr,
                               input logic lg, input logic fl, input logic dn);
    ID_valid = v;  ID_rs1 = r1; ID_use_rs1 = u1; ID_rs2 = r2; ID_use_rs2 = u2;
    ID_rd = rd; ID_RegWrite = wr; ID_MemRead = mr; ID_long = lg;
    EX_flush = fl; long_done = dn;
    #1;
  endtask

  task automatic idle(input logic dn);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, dn);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlow(input string tag, input logic s, input logic i);
    checkOutput({tag, ".stall"}, 32'(stall), 32'(s));
    checkOutput({tag, ".issue"}, 32'(issue), 32'(i));
    checkOutput({tag, ".bubble"}, 32'(bubble), 32'(!i));
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b0);
    tick();
    checkFlow("rst_during", 1'b0, 1'b0);
    tick();
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_tmo", 32'(long_timeout), 32'd0);
    checkOutput("rst_perr", 32'(protocol_err), 32'd0);
    rst = 1'b0;
    tick();
    checkFlow("rst_after", 1'b0, 1'b0);

    // lw x5 ; add x6,x5,x1
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkFlow("lw_issue", 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlow("lu_stall", 1'b1, 1'b0);
    tick();
    checkFlow("lu_release", 1'b0, 1'b1);
    checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // lw x0 ; add x7,x0,x0
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlow("lw_x0", 1'b0, 1'b1);
    tick();
    // lw x5 ; add x7,x8,x9
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlow("lw_unrel", 1'b0, 1'b1);
    tick();
    // lw x5 ; instruction naming x5 in rs2 but not reading it
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd2, 1'b1, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlow("lw_unused", 1'b0, 1'b1);
    tick();
    checkOutput("nostall_cnt", 32'(stall_cnt), 32'd1);

    // div x10, done 20 cycles later; add x11,x10,x2 waits through done cycle
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkFlow("div_issue", 1'b0, 1'b1);
    tick();
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(1'b1, 5'd10, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0,
                    (c == 20));
      if (c == 1 || c == 20) checkFlow($sformatf("raw_c%0d", c), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 5'd10, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlow("raw_release", 1'b0, 1'b1);
    checkOutput("raw_stall_cnt", 32'(stall_cnt), 32'd21);
    tick();

    // div x10 ; add x10,x3,x4 (WAW only), done on the third stall cycle
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0,
                    (c == 3));
      checkFlow($sformatf("waw_c%0d", c), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlow("waw_release", 1'b0, 1'b1);
    tick();

    // div x12 ; div x13 structural hazard
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0,
                    (c == 3));
      checkFlow($sformatf("struct_c%0d", c), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkFlow("struct_release", 1'b0, 1'b1);
    tick();
    idle(1'b1);
    tick();
    checkOutput("struct_stall_cnt", 32'(stall_cnt), 32'd27);

    // div x0 ; add x0,x0,x0 never stalls
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlow("div_x0", 1'b0, 1'b1);
    tick();
    idle(1'b1);
    tick();
    checkOutput("div_x0_perr", 32'(protocol_err), 32'd0);

    // Flush over a stalled load-use, then a flushed load sets nothing
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkFlow("flush_lu", 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkFlow("flush_lw", 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlow("flush_after", 1'b0, 1'b1);
    tick();
    checkOutput("flush_stall_cnt", 32'(stall_cnt), 32'd27);

    // Stray long_done, then a long op that never completes
    idle(1'b1);
    tick();
    checkOutput("stray_perr", 32'(protocol_err), 32'd1);
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    for (int c = 0; c < 10; c++) tick();
    checkOutput("tmo_early", 32'(long_timeout), 32'd0);
    for (int c = 0; c < 60; c++) tick();
    checkOutput("tmo_set", 32'(long_timeout), 32'd1);

    // Reset mid-long-op clears flags and discards the pending op
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst2_tmo", 32'(long_timeout), 32'd0);
    checkOutput("rst2_perr", 32'(protocol_err), 32'd0);
    checkOutput("rst2_stall_cnt", 32'(stall_cnt), 32'd0);
    applyStimulus(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkFlow("rst2_nodep", 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle(1'b1);
    tick();
    checkOutput("rst2_late_done", 32'(protocol_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter LONG_TIMEOUT, default 64: long-op busy cycles before timeout flag sets.
REQ-002 Parameter CNT_W, default 16: stall counter width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset:
clk  in  1  sole clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
REQ-004 Ports SHALL be:
ID_valid  in  1  valid instruction in ID.
ID_rs1, ID_rs2  in  5 each  source registers.
ID_use_rs1, ID_use_rs2  in  1 each  source actually read.
ID_rd  in  5  destination register.
ID_RegWrite  in  1  instruction writes rd.
ID_MemRead  in  1  instruction is a load.
ID_long  in  1  multi-cycle op (iterative mul/div in EX).
EX_flush  in  1  taken branch/jump resolved in EX; kills ID.
long_done  in  1  long unit writes its result this cycle.
stall  out  1  hold PC and IF/ID.
issue  out  1  ID instruction enters ID/EX this cycle.
bubble  out  1  load NOP into ID/EX.
stall_cnt  out  CNT_W  saturating count of stall cycles.
long_timeout  out  1  sticky: long op exceeded LONG_TIMEOUT.
protocol_err  out  1  sticky: long_done with no pending long op.

Function
REQ-005 State SHALL be: load_pending, load_rd[4:0], long_pending, long_rd[4:0], tmo_cnt, stall_cnt, two sticky flags.
REQ-006 load_use SHALL be: load_pending and load_rd != 0 and ((ID_use_rs1 and ID_rs1 == load_rd) or (ID_use_rs2 and ID_rs2 == load_rd)).
REQ-007 long_raw SHALL be: long_pending and long_rd != 0 and a used source equals long_rd; long_done in the same cycle does not suppress it (no long-unit bypass).
REQ-008 long_waw SHALL be: long_pending and ID_RegWrite and ID_rd != 0 and ID_rd == long_rd.
REQ-009 long_struct SHALL be: long_pending and ID_long, including the long_done cycle.
REQ-010 stall SHALL be ID_valid and not EX_flush and (load_use or long_raw or long_waw or long_struct); combinational.
REQ-011 issue SHALL be ID_valid and not EX_flush and not stall; bubble SHALL be not issue.
REQ-012 On each edge: load_pending <= issue and ID_MemRead and ID_RegWrite; load_rd <= ID_rd. Any load bubble therefore lasts exactly 1 cycle.
REQ-013 long_pending SHALL set on issue and ID_long (also when rd = 0) and load long_rd <= ID_rd; it SHALL clear on long_done. Set and clear cannot coincide (REQ-009).
REQ-014 long_done while long_pending = 0 SHALL be ignored and SHALL set protocol_err.
REQ-015 tmo_cnt SHALL clear when long_pending sets, increment each cycle long_pending = 1, and hold at LONG_TIMEOUT. Reaching LONG_TIMEOUT SHALL set long_timeout.
REQ-016 stall_cnt SHALL increment on every cycle with stall = 1 and saturate at all-ones.
REQ-017 EX_flush SHALL suppress issue and stall and set no scoreboard state. Pending long ops still complete.
REQ-018 Comparisons against register 0 SHALL never cause a stall.

Reset
REQ-019 On rst = 1 at a clock edge, all state SHALL clear to 0, including sticky flags and stall_cnt. Reset mid-long-op discards it; a later long_done then sets protocol_err.
REQ-020 During and after reset with ID_valid = 0, outputs SHALL be: stall = 0, issue = 0, bubble = 1.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Load-use: issue lw x5, next ID add x6,x5,x1 -> stall = 1 for 1 cycle, bubble = 1, then issue = 1; stall_cnt = 1.
- Load then x0 or unrelated use: lw x0 then add x7,x0,x0, or lw x5 then add x7,x8,x9 -> no stall.
- Long RAW plus WAW: div x10 issued, done after 20 cycles; ID add x11,x10,x2, then add x10,x3,x4 -> stall held through the done cycle, issue the following cycle.
- Structural: div pending, second div in ID -> stall until the cycle after long_done.
- Flush: EX_flush with a stalled load-use in ID -> stall = 0, issue = 0, bubble = 1, no load_pending set.
- Errors: long op with no long_done for 64 cycles -> long_timeout = 1; stray long_done -> protocol_err = 1; rst clears both.
